// File: rtl/autosa_cacc_group_sched_if.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// autosa_cacc_group_sched_if: launch/complete handshake between the
// CACC group scheduler (master) and the CACC datapath (slave).
// Revision: 1.0
// ------------------------------------------------------------------
interface autosa_cacc_group_sched_if;
  logic dp_start;
  logic dp_rdy;
  logic dp_group;
  logic dp_done;

  modport master (output dp_start, output dp_group, input dp_rdy, input dp_done);
  modport slave  (input dp_start, input dp_group, output dp_rdy, output dp_done);
endinterface
`default_nettype wire

// File: rtl/autosa_cacc_group_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// autosa_cacc_group_sched: in-order ping-pong launch/retire scheduler
// for the two CACC register groups. Optional run watchdog enabled by
// macro AUTOSA_CACC_RUN_TIMEOUT_EN.
// Revision: 1.0
// ------------------------------------------------------------------
module autosa_cacc_group_sched #(
  parameter int unsigned TIMEOUT_W      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic                      autosa_core_clk,
  input  logic                      autosa_core_rstn,
  input  logic                      op_en_wr_0,
  input  logic                      op_en_wr_1,
  input  logic                      op_en_wdata,
  autosa_cacc_group_sched_if.master dp,
  output logic                      consumer,
  output logic [1:0]                status_0,
  output logic [1:0]                status_1,
  output logic                      op_en_0,
  output logic                      op_en_1,
  output logic [1:0]                done_irq,
  output logic                      timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_W < 1) begin : g_bad_timeout_cfg
    $error("autosa_cacc_group_sched: TIMEOUT_CYCLES and TIMEOUT_W must be >= 1");
  end

  state_t     state_q, state_d;
  logic       consumer_q, consumer_d;
  logic [1:0] op_en_q, op_en_d;
  logic [1:0] done_irq_q, done_irq_d;
  logic       dp_start_q, dp_start_d;
  logic [1:0] wr;
  logic       retire;
`ifdef AUTOSA_CACC_RUN_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 timeout_err_q, timeout_err_d;
  logic                 to_hit;
`endif

  always_comb begin
    state_d    = state_q;
    consumer_d = consumer_q;
    op_en_d    = op_en_q;
    done_irq_d = 2'b00;
    retire     = 1'b0;
    wr         = {op_en_wr_1, op_en_wr_0};
`ifdef AUTOSA_CACC_RUN_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_err_d = 1'b0;
    to_hit        = 1'b0;
`endif
    // The group owned by hardware is locked once it leaves IDLE.
    for (int g = 0; g < 2; g++) begin
      if (wr[g] && !((1'(g) == consumer_q) && (state_q != ST_IDLE))) begin
        op_en_d[g] = op_en_wdata;
      end
    end
    case (state_q)
      ST_IDLE: begin
        if (op_en_q[consumer_q]) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        if (dp.dp_rdy) begin
          state_d = ST_RUN;
`ifdef AUTOSA_CACC_RUN_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      ST_RUN: begin
        retire = dp.dp_done;
`ifdef AUTOSA_CACC_RUN_TIMEOUT_EN
        to_hit = !dp.dp_done && (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
        retire = retire | to_hit;
        cnt_d  = cnt_q + TIMEOUT_W'(1);
`endif
        if (retire) begin
          state_d              = ST_IDLE;
          op_en_d[consumer_q]  = 1'b0;
          consumer_d           = ~consumer_q;
          done_irq_d[consumer_q] = 1'b1;
`ifdef AUTOSA_CACC_RUN_TIMEOUT_EN
          timeout_err_d = to_hit;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
    dp_start_d = (state_d == ST_LAUNCH);
  end

  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      state_q    <= ST_IDLE;
      consumer_q <= 1'b0;
      op_en_q    <= 2'b00;
      done_irq_q <= 2'b00;
      dp_start_q <= 1'b0;
`ifdef AUTOSA_CACC_RUN_TIMEOUT_EN
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      consumer_q <= consumer_d;
      op_en_q    <= op_en_d;
      done_irq_q <= done_irq_d;
      dp_start_q <= dp_start_d;
`ifdef AUTOSA_CACC_RUN_TIMEOUT_EN
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  always_comb begin
    status_0 = ((consumer_q == 1'b0) && (state_q != ST_IDLE)) ? 2'd1 :
               op_en_q[0] ? 2'd2 : 2'd0;
    status_1 = ((consumer_q == 1'b1) && (state_q != ST_IDLE)) ? 2'd1 :
               op_en_q[1] ? 2'd2 : 2'd0;
  end

  assign dp.dp_start = dp_start_q;
  assign dp.dp_group = consumer_q;
  assign consumer    = consumer_q;
  assign op_en_0     = op_en_q[0];
  assign op_en_1     = op_en_q[1];
  assign done_irq    = done_irq_q;
`ifdef AUTOSA_CACC_RUN_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_autosa_cacc_group_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// tb_autosa_cacc_group_sched: directed + random bench with a
// transaction-level scheduler model.
// Revision: 1.0
// ------------------------------------------------------------------
module tb_autosa_cacc_group_sched;
  localparam int unsigned TO = 8;
`ifdef AUTOSA_CACC_RUN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic wr0 = 1'b0, wr1 = 1'b0, wd = 1'b0;
  logic consumer, oe0, oe1, terr;
  logic [1:0] st0, st1, irq;

  autosa_cacc_group_sched_if dp_if();

  autosa_cacc_group_sched #(.TIMEOUT_W(16), .TIMEOUT_CYCLES(TO)) dut (
    .autosa_core_clk (clk),
    .autosa_core_rstn(rstn),
    .op_en_wr_0      (wr0),
    .op_en_wr_1      (wr1),
    .op_en_wdata     (wd),
    .dp              (dp_if),
    .consumer        (consumer),
    .status_0        (st0),
    .status_1        (st1),
    .op_en_0         (oe0),
    .op_en_1         (oe1),
    .done_irq        (irq),
    .timeout_err     (terr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: who owns the hardware, and whether its job is waiting for
  // acceptance or executing.
  bit       m_cons, m_launch, m_run, m_terr;
  bit [1:0] m_oe, m_irq;
  int       m_runcyc;

  function automatic void model_reset();
    m_cons = 0; m_launch = 0; m_run = 0; m_terr = 0;
    m_oe = 0; m_irq = 0; m_runcyc = 0;
  endfunction

  function automatic void model_step(bit w0, bit w1, bit d, bit rdy, bit done);
    bit [1:0] oe_old = m_oe;
    bit       busy = m_launch || m_run;
    m_irq = 0; m_terr = 0;
    if (w0 && !(m_cons == 0 && busy)) m_oe[0] = d;
    if (w1 && !(m_cons == 1 && busy)) m_oe[1] = d;
    if (m_run) begin
      m_runcyc++;
      if (done || (TO_EN && m_runcyc == int'(TO))) begin
        m_terr = !done;
        m_irq[m_cons] = 1;
        m_oe[m_cons] = 0;
        m_cons = !m_cons;
        m_run = 0;
      end
    end else if (m_launch) begin
      if (rdy) begin m_launch = 0; m_run = 1; m_runcyc = 0; end
    end else if (oe_old[m_cons]) begin
      m_launch = 1;
    end
  endfunction

  function automatic bit [1:0] m_status(bit g);
    if (g == m_cons && (m_launch || m_run)) return 2'd1;
    return m_oe[g] ? 2'd2 : 2'd0;
  endfunction

  // Field order: dp_start dp_group consumer status_0 status_1 op_en_0 op_en_1 done_irq timeout_err
  function automatic logic [11:0] model_vec();
    return {m_launch, m_cons, m_cons, m_status(0), m_status(1), m_oe[0], m_oe[1], m_irq, m_terr};
  endfunction

  function automatic logic [11:0] dut_vec();
    return {dp_if.dp_start, dp_if.dp_group, consumer, st0, st1, oe0, oe1, irq, terr};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rstn) model_step(wr0, wr1, wd, dp_if.dp_rdy, dp_if.dp_done);
    else model_reset();
    @(negedge clk);
    check("outputs_vs_model", {20'd0, dut_vec()}, {20'd0, model_vec()});
  endtask

  task automatic write(bit g, bit d);
    wd = d;
    if (g) wr1 = 1'b1; else wr0 = 1'b1;
    cycle();
    wr0 = 1'b0; wr1 = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    model_reset();
    #1;
    check("reset_outputs_zero", {20'd0, dut_vec()}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    dp_if.dp_rdy = 1'b0;
    dp_if.dp_done = 1'b0;
    model_reset();
    repeat (2) cycle();
    check("reset_consumer", consumer, 0);
    check("reset_status_0", st0, 0);
    check("reset_dp_start", dp_if.dp_start, 0);
    rstn = 1'b1;

    // Launch latency and LAUNCH hold
    write(0, 1);
    check("wr_op_en_0", oe0, 1);
    check("wr_status_0_pending", st0, 2);
    check("wr_no_start_yet", dp_if.dp_start, 0);
    cycle();
    check("launch_dp_start", dp_if.dp_start, 1);
    check("launch_dp_group", dp_if.dp_group, 0);
    check("launch_status_0", st0, 1);
    repeat (5) begin
      cycle();
      check("hold_dp_start", dp_if.dp_start, 1);
    end
    dp_if.dp_rdy = 1'b1; cycle(); dp_if.dp_rdy = 1'b0;
    check("run_dp_start_low", dp_if.dp_start, 0);
    check("run_status_0", st0, 1);
    dp_if.dp_done = 1'b1; cycle(); dp_if.dp_done = 1'b0;
    check("retire_irq", irq, 2'b01);
    check("retire_consumer", consumer, 1);
    check("retire_op_en_0", oe0, 0);
    check("retire_status_0", st0, 0);

    // Strict in-order: non-consumer pending alone never launches
    do_reset();
    write(1, 1);
    repeat (20) begin
      cycle();
      check("in_order_no_start", dp_if.dp_start, 0);
    end
    write(0, 1);
    cycle();
    check("g0_launch", {dp_if.dp_start, dp_if.dp_group}, 2'b10);
    dp_if.dp_rdy = 1'b1; cycle(); dp_if.dp_rdy = 1'b0;
    repeat (3) cycle();
    dp_if.dp_done = 1'b1; cycle(); dp_if.dp_done = 1'b0;
    check("b2b_irq", irq, 2'b01);
    check("b2b_consumer", consumer, 1);
    check("b2b_gap_no_start", dp_if.dp_start, 0);
    check("b2b_status_1_pending", st1, 2);
    cycle();
    check("b2b_g1_launch", {dp_if.dp_start, dp_if.dp_group}, 2'b11);
    check("b2b_status_1_running", st1, 1);

    // Locked running group, free non-consumer group
    dp_if.dp_rdy = 1'b1; cycle(); dp_if.dp_rdy = 1'b0;
    write(1, 0);
    check("locked_status_1", st1, 1);
    check("locked_op_en_1", oe1, 1);
    write(0, 1);
    check("other_pending", st0, 2);
    write(0, 0);
    check("other_cancel", st0, 0);

    // Reset mid-RUN, then stray dp_done ignored
    do_reset();
    dp_if.dp_done = 1'b1;
    repeat (3) cycle();
    dp_if.dp_done = 1'b0;
    check("post_reset_no_irq", irq, 0);
    check("post_reset_no_start", dp_if.dp_start, 0);

    if (TO_EN) begin
      write(0, 1);
      cycle();
      dp_if.dp_rdy = 1'b1; cycle(); dp_if.dp_rdy = 1'b0;
      repeat (TO - 1) begin
        cycle();
        check("to_wait_no_irq", irq, 0);
      end
      cycle();
      check("to_irq", irq, 2'b01);
      check("to_err", terr, 1);
      write(1, 1);
      cycle();
      dp_if.dp_rdy = 1'b1; cycle(); dp_if.dp_rdy = 1'b0;
      repeat (TO - 1) cycle();
      dp_if.dp_done = 1'b1; cycle(); dp_if.dp_done = 1'b0;
      check("to_done_wins_irq", irq, 2'b10);
      check("to_done_wins_err", terr, 0);
    end

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      wr0 = ($urandom_range(0, 3) == 0);
      wr1 = ($urandom_range(0, 3) == 0);
      wd  = 1'($urandom_range(0, 1));
      dp_if.dp_rdy  = ($urandom_range(0, 2) != 0);
      dp_if.dp_done = ($urandom_range(0, 4) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
endmodule
`default_nettype wire

// File: doc/autosa_cacc_group_sched.md
Name: autosa_cacc_group_sched

Overview:
Ping-pong scheduler for the two CACC register groups (group 0 / group 1). It tracks per-group op_en and launches the CACC datapath strictly in consumer-pointer order. It also retires each operation on datapath completion. It produces the consumer pointer and the 2-bit per-group status that the single-register block exposes for readback.

Parameters:
TIMEOUT_W, 16, width of the run watchdog counter (used only with the optional feature).
TIMEOUT_CYCLES, 16'hFFFF, RUN cycles without dp_done before a forced retire (optional feature only); must be ≥1.

Ports:
autosa_core_clk  in  1  core clock, all flops on rising edge
autosa_core_rstn  in  1  asynchronous, active-low reset
op_en_wr_0  in  1  write strobe for group 0 op_en field
op_en_wr_1  in  1  write strobe for group 1 op_en field
op_en_wdata  in  1  op_en value written (bit 0 of write data)
dp_start  out  1  launch request to datapath, valid-style
dp_rdy  in  1  datapath accepts launch
dp_group  out  1  group being launched/run (= consumer)
dp_done  in  1  single-cycle completion pulse from datapath
consumer  out  1  group currently owned by hardware
status_0  out  2  group 0 status: 0 IDLE, 1 RUNNING, 2 PENDING
status_1  out  2  group 1 status, same encoding
op_en_0  out  1  group 0 op_en readback
op_en_1  out  1  group 1 op_en readback
done_irq  out  2  one-cycle per-group completion pulse, bit g = group g
timeout_err  out  1  one-cycle pulse on watchdog retire

Behaviour:
- Reset values: all outputs 0. FSM in IDLE, consumer=0, op_en_0/1=0.
- FSM states: IDLE, LAUNCH, RUN.
- op_en write rules:
  - op_en_wr_g: op_en_g <= op_en_wdata on the next edge.
  - Exception: a write is ignored when g==consumer and state!=IDLE. Running and launching groups are locked and cannot be aborted.
  - Writing 0 to a pending group cancels it. Writing 1 to an already-set group is a no-op.
- IDLE: if op_en[consumer]==1, go to LAUNCH. A set op_en on the non-consumer group alone never launches (strict in-order).
- Launch latency: op_en write at cycle N → op_en visible at N+1 → LAUNCH (dp_start=1) at N+2.
- LAUNCH:
  - dp_start=1 and dp_group=consumer, held until dp_rdy.
  - On dp_start&&dp_rdy, go to RUN next cycle; dp_start deasserts.
- RUN: dp_done sampled at cycle M. At M+1:
  - state=IDLE, op_en[g]=0, consumer=~g.
  - done_irq[g]=1 for exactly that cycle.
- Back-to-back: if the other group is already pending, LAUNCH at M+2.
- dp_done outside RUN is ignored.
- An op_en write to the non-consumer group in the same cycle as dp_done takes effect normally.
- A write to the retiring group in the dp_done cycle is ignored (locked).
- status_g, combinational from registered state:
  - RUNNING if g==consumer and state∈{LAUNCH,RUN};
  - else PENDING if op_en_g;
  - else IDLE.
  - Value 3 is never produced.
- Reset mid-operation returns everything to reset values immediately; no done_irq is issued.

Optional Feature:
Macro AUTOSA_CACC_RUN_TIMEOUT_EN.
- Defined:
  - A TIMEOUT_W-bit counter clears on entry to RUN and increments each RUN cycle.
  - When the counter==TIMEOUT_CYCLES-1 with no dp_done, the block retires exactly as for dp_done, and timeout_err pulses together with done_irq.
  - dp_done in the same cycle wins: normal retire, no timeout_err.
- Undefined: no counter; timeout_err tied 0; RUN waits indefinitely for dp_done.

Test Plan:
- Reset, then op_en_wr_0 with wdata=1 at cycle 0 → op_en_0=1 and status_0=2 at cycle 1; dp_start=1, dp_group=0, status_0=1 at cycle 2.
- Hold dp_rdy=0 for 5 cycles in LAUNCH → dp_start stays 1. Raise dp_rdy → RUN, dp_start=0. Pulse dp_done → next cycle: done_irq=2'b01, consumer=1, op_en_0=0, status_0=0.
- Set op_en_1 only, consumer=0 → no dp_start for 20 cycles. Then set op_en_0 → launches group 0; after its done, group 1 launches 1 cycle after retire (M+2).
- While group 0 is in RUN: write op_en_0=0 → ignored, status_0 stays 1. Write op_en_1=1 then op_en_1=0 → status_1 goes 2 then 0.
- Assert reset during RUN → all outputs 0, no done_irq. After release, dp_done pulses are ignored.
- Macro defined, TIMEOUT_CYCLES=8, no dp_done → retire after 8 RUN cycles with timeout_err=1 and done_irq pulse. Repeat with dp_done on cycle 8 → timeout_err=0.
